uart_word_ctrl: RTL and testbench

UART_WORD_CTRL -- requirements
Module: uart_word_ctrl

---
 rtl/uart_word_pkg.sv | 8 +
 rtl/uart_word_ctrl.sv | 131 +++++++++++++
 tb/tb_uart_word_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_pkg.sv
// uart_word_pkg: state encoding and UART slave register map shared by uart_word_ctrl
package uart_word_pkg;
    typedef enum logic [2:0] {IDLE, RD_STAT, RD_DATA, WR, WR_RESP} state_t;
    localparam logic [3:0] TX_FIFO   = 4'h4;
    localparam logic [3:0] STAT_REG  = 4'h8;
    localparam int         TX_FULL   = 3;
    localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/uart_word_ctrl.sv
// uart_word_ctrl: splits a word into bytes and pushes each into a UART TX FIFO over AXI-Lite, polling status first
module uart_word_ctrl
    import uart_word_pkg::*;
#(
    parameter int         DATA_W    = 16,
    parameter int         MSB_FIRST = 1,
    parameter int         SYNC_EN   = 0,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic [3:0]        awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [7:0]        wdata,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [3:0]        araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [7:0]        rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic              err,
    output logic              busy
);
    localparam int DB = DATA_W / 8;
    localparam int NB = DB + SYNC_EN;
    localparam int CW = $clog2(NB + 1);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    if (DATA_W < 8 || DATA_W > 64 || DATA_W % 8 != 0) begin : g_bad_width
        $error("uart_word_ctrl: DATA_W must be a multiple of 8 between 8 and 64");
    end

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [DATA_W-1:0]   word;
    logic [7:0]          cur_byte;
    int                  d;
    int                  k;
    logic                unused_rdata;

    assign awaddr       = TX_FIFO;
    assign araddr       = STAT_REG;
    assign unused_rdata = ^{rdata[7:TX_FULL+1], rdata[TX_FULL-1:0]};

    // Byte for the current count: sync byte leads, data bytes follow in the configured order
    always_comb begin
        d        = int'(cnt) - ((SYNC_EN != 0 && cnt != '0) ? 1 : 0);
        d        = (d >= DB) ? DB - 1 : d;
        k        = (MSB_FIRST != 0) ? DB - 1 - d : d;
        cur_byte = (SYNC_EN != 0 && cnt == '0) ? SYNC_BYTE : word[8*k +: 8];
    end

    // Word sequencer: poll status, write one byte, wait for the response, repeat until all bytes are out
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            word    <= '0;
            wdata   <= '0;
            err     <= 1'b0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            ready   <= 1'b1;
            busy    <= 1'b0;
        end else begin
            if ((bvalid && bready && bresp != RESP_OKAY) || (rvalid && rready && rresp != RESP_OKAY))
                err <= 1'b1;
            case (state)
                IDLE: if (valid) begin
                    word    <= data;
                    cnt     <= '0;
                    arvalid <= 1'b1;
                    ready   <= 1'b0;
                    busy    <= 1'b1;
                    state   <= RD_STAT;
                end
                RD_STAT: if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    state   <= RD_DATA;
                end
                RD_DATA: if (rvalid) begin
                    rready <= 1'b0;
                    if (rdata[TX_FULL]) begin
                        arvalid <= 1'b1;
                        state   <= RD_STAT;
                    end else begin
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        wdata   <= cur_byte;
                        state   <= WR;
                    end
                end
                WR: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready) wvalid <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: if (bvalid) begin
                    bready <= 1'b0;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        arvalid <= 1'b1;
                        state   <= RD_STAT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_word_ctrl.sv
// tb_uart_word_ctrl: directed checks of uart_word_ctrl against a small reactive AXI-Lite UART slave
module tb_uart_word_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] data;
    logic        valid, ready, busy, err;
    logic [3:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [7:0]  wdata, rdata;
    logic [1:0]  bresp, rresp;

    logic [31:0] data_b;
    logic        valid_b, ready_b, busy_b, err_b;
    logic [3:0]  awaddr_b, araddr_b;
    logic        awvalid_b, awready_b, wvalid_b, wready_b, bvalid_b, bready_b, arvalid_b, arready_b, rvalid_b, rready_b;
    logic [7:0]  wdata_b, rdata_b;
    logic [1:0]  bresp_b, rresp_b;

    uart_word_ctrl dut (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .err(err), .busy(busy)
    );

    uart_word_ctrl #(.DATA_W(32), .MSB_FIRST(0), .SYNC_EN(1)) dut_b (
        .clk(clk), .rst(rst), .data(data_b), .valid(valid_b), .ready(ready_b),
        .awaddr(awaddr_b), .awvalid(awvalid_b), .awready(awready_b),
        .wdata(wdata_b), .wvalid(wvalid_b), .wready(wready_b),
        .bresp(bresp_b), .bvalid(bvalid_b), .bready(bready_b),
        .araddr(araddr_b), .arvalid(arvalid_b), .arready(arready_b),
        .rdata(rdata_b), .rresp(rresp_b), .rvalid(rvalid_b), .rready(rready_b),
        .err(err_b), .busy(busy_b)
    );

    int n_assert = 0;
    int n_fail = 0;

    int ar_n = 0, aw_n = 0, w_n = 0, b_n = 0, bad_addr = 0, unstable = 0, r = 0;
    int full_until = 0, bad_b = -1;
    bit stall_en = 0;
    int aw_wait = 0, w_wait = 0, aw_dly = 0, w_dly = 0;
    logic [7:0] wlog[$];
    logic [7:0] wlog_b[$];
    int aw_at_ar[$];
    bit p_awp = 0, p_wp = 0;
    logic [3:0] p_awaddr;
    logic [7:0] p_wdata;

    assign arready = 1'b1;
    assign rresp   = 2'b00;
    assign awready = awvalid && (aw_wait >= aw_dly);
    assign wready  = wvalid && (w_wait >= w_dly);

    // Slave for the default instance: status replies, optional write stalls, one response per completed write
    always @(posedge clk) begin
        if (rst) begin
            rvalid  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            rdata   <= 8'h00;
            aw_wait <= 0;
            w_wait  <= 0;
            b_n = (aw_n < w_n) ? aw_n : w_n;
            p_awp = 0;
            p_wp = 0;
        end else begin
            if (p_awp && (!awvalid || awaddr !== p_awaddr)) unstable++;
            if (p_wp && (!wvalid || wdata !== p_wdata)) unstable++;
            p_awp = awvalid && !awready;
            p_awaddr = awaddr;
            p_wp = wvalid && !wready;
            p_wdata = wdata;
            if (arvalid && arready) begin
                ar_n++;
                aw_at_ar.push_back(aw_n);
                rvalid <= 1'b1;
                rdata  <= (ar_n <= full_until) ? 8'h08 : 8'h00;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
            if (awvalid && awready) begin
                aw_n++;
                if (awaddr !== 4'h4) bad_addr++;
            end
            if (wvalid && wready) begin
                w_n++;
                wlog.push_back(wdata);
            end
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            if (!awvalid && !wvalid) begin
                r = stall_en ? int'($urandom_range(0, 2)) : 0;
                aw_dly <= stall_en ? r + 3 : 0;
                w_dly  <= r;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
                b_n++;
            end else if (!bvalid && aw_n > b_n && w_n > b_n) begin
                bvalid <= 1'b1;
                bresp  <= (b_n == bad_b) ? 2'b10 : 2'b00;
            end
        end
    end

    assign arready_b = 1'b1;
    assign awready_b = 1'b1;
    assign wready_b  = 1'b1;
    assign rresp_b   = 2'b00;
    assign bresp_b   = 2'b00;
    assign rdata_b   = 8'h00;

    // Always-ready slave for the 32-bit instance, logging each written byte
    always @(posedge clk) begin
        if (rst) begin
            rvalid_b <= 1'b0;
            bvalid_b <= 1'b0;
        end else begin
            if (arvalid_b) rvalid_b <= 1'b1;
            else if (rvalid_b && rready_b) rvalid_b <= 1'b0;
            if (wvalid_b) wlog_b.push_back(wdata_b);
            if (bvalid_b && bready_b) bvalid_b <= 1'b0;
            else if (awvalid_b && wvalid_b) bvalid_b <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input int noise, output int cyc);
        data  = d;
        valid = 1'b1;
        @(negedge clk);
        chk("cap_ready", ready, 0);
        chk("cap_busy", busy, 1);
        chk("cap_ar", {arvalid, araddr}, {1'b1, 4'h8});
        cyc   = 1;
        data  = ~d;
        valid = (noise > 0);
        while (!ready && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc > noise) valid = 1'b0;
        end
        valid = 1'b0;
        chk("done_ready", ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, base, awb, arb;
        logic [7:0] exp_b[5];
        exp_b = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11};
        valid = 1'b0;
        data = '0;
        valid_b = 1'b0;
        data_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", ready, 1);
        chk("post_rst_busy", busy, 0);

        base = wlog.size();
        awb = aw_n;
        send(16'hBEEF, 3, cyc);
        chk("t1_cycles", cyc, 9);
        chk("t1_nwr", wlog.size() - base, 2);
        chk("t1_byte0", wlog[base], 8'hBE);
        chk("t1_byte1", wlog[base+1], 8'hEF);
        chk("t1_naw", aw_n - awb, 2);
        chk("t1_awaddr", bad_addr, 0);
        chk("t1_err", err, 0);

        base = wlog_b.size();
        data_b = 32'h11223344;
        valid_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0;
        cyc = 1;
        while (!ready_b && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("b_ready", ready_b, 1);
        chk("b_cycles", cyc, 21);
        chk("b_nwr", wlog_b.size() - base, 5);
        for (int i = 0; i < 5; i++) chk("b_byte", wlog_b[base+i], exp_b[i]);
        chk("b_err", err_b, 0);

        base = wlog.size();
        awb = aw_n;
        arb = ar_n;
        full_until = ar_n + 3;
        send(16'hC0DE, 0, cyc);
        chk("t2_cycles", cyc, 15);
        chk("t2_nar", ar_n - arb, 5);
        chk("t2_aw_at_4th_ar", aw_at_ar[arb+3] - awb, 0);
        chk("t2_nwr", wlog.size() - base, 2);
        chk("t2_byte0", wlog[base], 8'hC0);
        chk("t2_byte1", wlog[base+1], 8'hDE);

        base = wlog.size();
        awb = aw_n;
        stall_en = 1;
        send(16'h5AC3, 0, cyc);
        stall_en = 0;
        chk("t3_stalled", cyc >= 15, 1);
        chk("t3_nwr", wlog.size() - base, 2);
        chk("t3_naw", aw_n - awb, 2);
        chk("t3_byte0", wlog[base], 8'h5A);
        chk("t3_byte1", wlog[base+1], 8'hC3);
        chk("t3_stable", unstable, 0);
        chk("t3_err", err, 0);

        base = wlog.size();
        bad_b = b_n;
        send(16'h1357, 0, cyc);
        bad_b = -1;
        chk("t4_err", err, 1);
        chk("t4_cycles", cyc, 9);
        chk("t4_nwr", wlog.size() - base, 2);
        chk("t4_byte1", wlog[base+1], 8'h57);
        send(16'h2468, 0, cyc);
        chk("t4_err_sticky", err, 1);

        base = wlog.size();
        data = 16'hA1B2;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        for (int i = 0; i < 50 && !bready; i++) @(negedge clk);
        chk("t5_bready", bready, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
        chk("t5_ready", ready, 1);
        chk("t5_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_ready_after", ready, 1);
        chk("t5_err_clear", err, 0);
        chk("t5_partial", wlog.size() - base, 1);
        base = wlog.size();
        send(16'h9C3D, 0, cyc);
        chk("t5_cycles", cyc, 9);
        chk("t5_nwr", wlog.size() - base, 2);
        chk("t5_byte0", wlog[base], 8'h9C);
        chk("t5_byte1", wlog[base+1], 8'h3D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
